// File: rtl/alu_chain_ctrl_if.sv
// Command / ALU / result bus of the multi-nibble ALU sequencer.
// master = environment side (command source, ALU, result sink); slave = sequencer.
interface alu_chain_ctrl_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [2:0]   cmd_s;
    logic         cmd_cin;
    logic         cmd_chain;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [2:0]   alu_s;
    logic         alu_cin;
    logic [3:0]   alu_f;
    logic         alu_cout;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cout;
    logic         res_zero;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_cin, cmd_chain,
        output alu_f, alu_cout, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_s, alu_cin,
        input  res_valid, res_f, res_cout, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_cin, cmd_chain,
        input  alu_f, alu_cout, res_ready,
        output cmd_ready, alu_a, alu_b, alu_s, alu_cin,
        output res_valid, res_f, res_cout, res_zero
    );
endinterface

// File: rtl/alu_chain_ctrl.sv
// Sequences a wide command through a 4-bit ALU one nibble at a time (LSB first),
// optionally rippling carry between nibbles, and assembles the wide result.
module alu_chain_ctrl #(
    parameter int NIBBLES = 4,
    parameter int ALU_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    alu_chain_ctrl_if.slave bus
);
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW = 2;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(ALU_LAT);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic [NIBBLES-1:0][3:0] a;
        logic [NIBBLES-1:0][3:0] b;
        logic                    cin;
        logic                    chain;
    } cmd_t;

    state_t                  state, state_nxt;
    cmd_t                    cmd_q;
    logic [KW-1:0]           k, k_inc;
    logic [CW-1:0]           cnt;
    logic [NIBBLES-1:0][3:0] res_q, res_nxt;
    logic                    res_cout_q, res_zero_q;
    logic [3:0]              alu_a_q, alu_b_q, nxt_a, nxt_b;
    logic [2:0]              alu_s_q;
    logic                    alu_cin_q;
    logic                    accept, capture, last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == C_LAST) begin
                    capture = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last  = (k == K_LAST);
    assign k_inc = last ? k : k + 1'b1;

    // Operand nibble for the next issue, picked from the latched command.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (KW'(i) == k_inc) begin
                nxt_a = cmd_q.a[i];
                nxt_b = cmd_q.b[i];
            end
        end
    end

    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        assign res_nxt[i] = (capture && k == KW'(i)) ? bus.alu_f : res_q[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q      <= '0;
            k          <= '0;
            cnt        <= '0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            res_zero_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            alu_cin_q  <= 1'b0;
        end else if (accept) begin
            cmd_q.a     <= bus.cmd_a;
            cmd_q.b     <= bus.cmd_b;
            cmd_q.cin   <= bus.cmd_cin;
            cmd_q.chain <= bus.cmd_chain;
            alu_a_q     <= bus.cmd_a[3:0];
            alu_b_q     <= bus.cmd_b[3:0];
            alu_s_q     <= bus.cmd_s;
            alu_cin_q   <= bus.cmd_cin;
            k           <= '0;
            cnt         <= '0;
        end else if (state == EXEC) begin
            if (capture) begin
                res_q <= res_nxt;
                cnt   <= '0;
                if (last) begin
                    res_cout_q <= bus.alu_cout;
                    // Zero flag judged on the fully assembled word, including this nibble.
                    res_zero_q <= (res_nxt == '0);
                end else begin
                    k         <= k_inc;
                    alu_a_q   <= nxt_a;
                    alu_b_q   <= nxt_b;
                    alu_cin_q <= cmd_q.chain ? bus.alu_cout : cmd_q.cin;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_s    = alu_s_q;
    assign bus.alu_cin  = alu_cin_q;
    assign bus.res_f    = res_q;
    assign bus.res_cout = res_cout_q;
    assign bus.res_zero = res_zero_q;
endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Bench for alu_chain_ctrl: directed vector table, backpressure and reset corners,
// then random commands against a whole-width arithmetic reference.
module tb_alu_chain_ctrl;
    localparam int NIBBLES = 4;
    localparam int ALU_LAT = 1;
    localparam int W       = 4 * NIBBLES;
    localparam int STEP    = 1 + ALU_LAT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    alu_chain_ctrl_if #(.W(W)) bus ();

    alu_chain_ctrl #(.NIBBLES(NIBBLES), .ALU_LAT(ALU_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // 4-bit ALU: S=000 add, S=001 A+~B+Cin (subtract), registered (latency 1).
    function automatic logic [4:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [2:0] s, logic cin);
        logic [3:0] bb;
        bb = (s == 3'b001) ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {4'b0, cin};
    endfunction

    always @(posedge clk) {bus.alu_cout, bus.alu_f} <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin);

    // Reference: chained = one wide addition; unchained = independent nibble sums.
    function automatic logic [W+1:0] ref_model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] s,
                                               logic cin, logic chain);
        logic [W-1:0] bb, f;
        logic [W:0]   sum;
        logic [4:0]   t;
        logic         cout;
        bb = (s == 3'b001) ? ~b : b;
        if (chain) begin
            sum  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
            f    = sum[W-1:0];
            cout = sum[W];
        end else begin
            f    = '0;
            cout = 1'b0;
            for (int i = 0; i < NIBBLES; i++) begin
                t          = {1'b0, a[4*i +: 4]} + {1'b0, bb[4*i +: 4]} + {4'b0, cin};
                f[4*i +: 4] = t[3:0];
                cout       = t[4];
            end
        end
        return {(f == '0), cout, f};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   s;
        logic         cin, chain;
        logic [W-1:0] ef;
        logic         ecout, ezero;
        logic [3:0]   ecins;
        bit           chk_cins;
    } vec_t;

    task automatic run_cmd(input vec_t v, input string nm, input bit scramble);
        int         lat, w;
        logic [3:0] cins;
        @(negedge clk);
        bus.cmd_a = v.a; bus.cmd_b = v.b; bus.cmd_s = v.s;
        bus.cmd_cin = v.cin; bus.cmd_chain = v.chain; bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({nm, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cins = '0;
        cins[0] = bus.alu_cin;
        if (scramble) begin
            bus.cmd_a = W'($urandom); bus.cmd_b = W'($urandom);
            bus.cmd_cin = ~v.cin; bus.cmd_chain = ~v.chain; bus.cmd_s = 3'($urandom);
        end
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e % STEP == 0 && e / STEP < NIBBLES) cins[e / STEP] = bus.alu_cin;
            if (bus.res_valid) begin
                lat = e;
                break;
            end
        end
        check({nm, ".latency"}, 32'(lat), 32'(NIBBLES * STEP));
        check({nm, ".res_f"}, 32'(bus.res_f), 32'(v.ef));
        check({nm, ".res_cout"}, 32'(bus.res_cout), 32'(v.ecout));
        check({nm, ".res_zero"}, 32'(bus.res_zero), 32'(v.ezero));
        if (v.chk_cins) check({nm, ".alu_cin_seq"}, 32'(cins), 32'(v.ecins));
        @(posedge clk);
        #1;
        check({nm, ".done_one_cycle"}, {30'd0, bus.res_valid, bus.cmd_ready}, 32'b01);
    endtask

    task automatic wait_res(input string nm);
        int w;
        w = 0;
        while (!bus.res_valid && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({nm, ".res_valid_seen"}, 32'(bus.res_valid), 32'd1);
    endtask

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  v;
        bit    seen;
        logic [W+1:0] r;
        //          a        b        s     cin   chain ef       cout  zero  cins     chk
        tbl[0] = '{16'h0FFF, 16'h0001, 3'd0, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 4'b1110, 1'b1};
        tbl[1] = '{16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1110, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0, 16'hFFF0, 1'b0, 1'b0, 4'b0000, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 4'b1111, 1'b1};
        tbl[4] = '{16'h0005, 16'h0003, 3'd1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 4'b1111, 1'b1};
        tbl[5] = '{16'h1234, 16'h1111, 3'd0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 4'b0000, 1'b1};

        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_s = '0;
        bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b0; bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) run_cmd(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Reset while idle with a non-zero result held.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.ready_valid", {30'd0, bus.cmd_ready, bus.res_valid}, 32'b10);
        check("rst.alu", {20'd0, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}, 32'd0);
        check("rst.res", {14'd0, bus.res_f, bus.res_cout, bus.res_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Backpressure with a second command pending.
        bus.res_ready = 1'b0;
        @(negedge clk);
        bus.cmd_a = 16'h00F0; bus.cmd_b = 16'h0010; bus.cmd_s = 3'd0;
        bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_res("bp1");
        @(negedge clk);
        bus.cmd_a = 16'h0005; bus.cmd_b = 16'h0003; bus.cmd_s = 3'd1;
        bus.cmd_cin = 1'b1; bus.cmd_chain = 1'b1; bus.cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.hold%0d.flags", c), {30'd0, bus.res_valid, bus.cmd_ready}, 32'b10);
            check($sformatf("bp.hold%0d.res", c), {15'd0, bus.res_f, bus.res_cout}, {15'd0, 16'h0100, 1'b0});
            check($sformatf("bp.hold%0d.alu_a", c), 32'(bus.alu_a), 32'h0);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release", {30'd0, bus.res_valid, bus.cmd_ready}, 32'b01);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("bp.accept2", {27'd0, bus.cmd_ready, bus.alu_a}, 32'h05);
        wait_res("bp2");
        check("bp2.res", {15'd0, bus.res_f, bus.res_cout}, {15'd0, 16'h0002, 1'b1});
        @(posedge clk);
        #1;

        // Reset while nibble 2 is in flight.
        @(negedge clk);
        bus.cmd_a = 16'hABCD; bus.cmd_b = 16'h1111; bus.cmd_s = 3'd0;
        bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (2 * STEP) @(posedge clk);
        #1;
        check("rmid.nibble2_issued", 32'(bus.alu_a), 32'hB);
        #2;
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen = 1'b1;
        end
        check("rmid.no_res_valid", 32'(seen), 32'd0);
        run_cmd(tbl[5], "rmid.after", 1'b0);

        // Random commands against the reference, with inputs scrambled during EXEC.
        for (int n = 0; n < 40; n++) begin
            v.a = W'($urandom); v.b = W'($urandom);
            v.s = 3'($urandom_range(0, 1));
            v.cin = 1'($urandom); v.chain = 1'($urandom);
            if (n % 10 == 0) begin
                v.b = (v.s == 3'd1) ? v.a : -v.a;
                v.cin = (v.s == 3'd1);
                v.chain = 1'b1;
            end
            r = ref_model(v.a, v.b, v.s, v.cin, v.chain);
            v.ef = r[W-1:0]; v.ecout = r[W]; v.ezero = r[W+1];
            v.ecins = '0; v.chk_cins = 1'b0;
            run_cmd(v, $sformatf("rnd%0d", n), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
